// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared stage payload layout and the per-stage clear/suppress masks built from it.
package pipe_stage_skid_reg_pkg;

  localparam int STAGE_W = 64;

  localparam int PC_LSB        = 0;
  localparam int PC_W          = 32;
  localparam int OP_LSB        = 32;
  localparam int OP_W          = 8;
  localparam int REG_D_LSB     = 40;
  localparam int REG_D_W       = 5;
  localparam int REG_D_WEN_BIT = 45;
  localparam int MM_RE_BIT     = 46;
  localparam int MM_WE_BIT     = 47;
  localparam int MM_SIZE_LSB   = 48;
  localparam int MM_SIZE_W     = 2;
  localparam int CSR_ADDR_LSB  = 50;
  localparam int CSR_ADDR_W    = 12;
  localparam int CSR_WE_BIT    = 62;
  localparam int EXC_BIT       = 63;

  function automatic logic [STAGE_W-1:0] field_mask(input int lsb, input int w);
    return ((STAGE_W'(1) << w) - STAGE_W'(1)) << lsb;
  endfunction

  // Flush-before cancels every architectural side effect but keeps pc/op for debug.
  localparam logic [STAGE_W-1:0] SUP_MASK_STAGE =
    field_mask(REG_D_WEN_BIT, 1) | field_mask(MM_RE_BIT, 1) |
    field_mask(MM_WE_BIT, 1)     | field_mask(CSR_WE_BIT, 1);
  localparam logic [STAGE_W-1:0] CLR_MASK_STAGE = '1;
  localparam logic [STAGE_W-1:0] CLR_MASK_CTRL  =
    SUP_MASK_STAGE | field_mask(EXC_BIT, 1);

  // Encoded as {main_v, skid_v}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_skid_reg_entry.sv
// One payload flop: clear-mask on flush has priority over load.
module pipe_entry_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] CLR_MASK = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (clr)  q <= q & ~CLR_MASK;
    else if (load) q <= d;
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready, optional 2-entry skid, flush and field masks.
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] CLR_MASK = {DATA_W{1'b1}},
  parameter logic [DATA_W-1:0] SUP_MASK = {DATA_W{1'b0}},
  parameter bit                SKID     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sup,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  skid_state_e state_q, state_d;
  logic main_v, skid_v, accept, pop;
  logic [DATA_W-1:0] cap;
  logic [1:0] load;
  logic [1:0][DATA_W-1:0] ent_d, ent_q;
  logic [1:0] occ_q;

  assign main_v = state_q[1];
  assign skid_v = state_q[0];

  // With SKID the ready is a flop output, breaking the out_ready -> in_ready chain.
  assign in_ready  = SKID ? !skid_v : (!main_v | out_ready);
  assign accept    = in_valid & in_ready & !flush;
  assign pop       = main_v & out_ready;
  assign cap       = in_data & ~(SUP_MASK & {DATA_W{in_sup}});
  assign out_valid = main_v;
  assign out_data  = ent_q[0];
  assign occupancy = occ_q;

  always_comb begin
    state_d  = state_q;
    load     = '0;
    ent_d[0] = cap;
    ent_d[1] = cap;
    if (!flush) begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d = ST_ONE;
          load[0] = 1'b1;
        end
        ST_ONE: begin
          if (accept && pop) begin
            load[0] = 1'b1;
          end else if (accept) begin
            state_d = ST_FULL;
            load[1] = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (pop) begin
          state_d  = ST_ONE;
          load[0]  = 1'b1;
          ent_d[0] = ent_q[1];
        end
        default: state_d = ST_EMPTY;
      endcase
    end else begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      occ_q   <= {1'b0, state_d[1]} + {1'b0, state_d[0]};
    end
  end

  // Entry 0 is the head (main), entry 1 the skid slot.
  for (genvar i = 0; i < 2; i++) begin : g_ent
    pipe_entry_reg #(
      .DATA_W   (DATA_W),
      .CLR_MASK (CLR_MASK)
    ) u_ent (
      .clk  (clk),
      .rst  (rst),
      .clr  (flush),
      .load (load[i]),
      .d    (ent_d[i]),
      .q    (ent_q[i])
    );
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench: SKID=1 and SKID=0 instances, scoreboard per instance plus point checks.
module tb_pipe_stage_skid_reg;

  localparam logic [7:0] CLR = 8'hF0;
  localparam logic [7:0] SUP = 8'h81;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;
  logic iv1, ir1, sup1, ov1, ordy1;
  logic [7:0] id1, od1;
  logic [1:0] occ1;
  logic iv0, ir0, sup0, ov0, ordy0;
  logic [7:0] id0, od0;
  logic [1:0] occ0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q1[$];
  logic [7:0] q0[$];

  pipe_stage_skid_reg #(.DATA_W(8), .CLR_MASK(CLR), .SUP_MASK(SUP), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv1), .in_ready(ir1),
    .in_data(id1), .in_sup(sup1), .out_valid(ov1), .out_ready(ordy1),
    .out_data(od1), .occupancy(occ1));

  pipe_stage_skid_reg #(.DATA_W(8), .CLR_MASK(CLR), .SUP_MASK(SUP), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv0), .in_ready(ir0),
    .in_data(id0), .in_sup(sup0), .out_valid(ov0), .out_ready(ordy0),
    .out_data(od0), .occupancy(occ0));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard on the falling edge, then advance past the next rising edge.
  task automatic cyc();
    logic [7:0] e;
    @(negedge clk);
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      if (ov1 && ordy1) begin
        chk("sb1_nonempty", 8'(q1.size() != 0), 8'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("sb1_data", od1, e);
        end
      end
      if (flush) q1.delete();
      else if (iv1 && ir1) q1.push_back(id1 & ~(sup1 ? SUP : 8'h00));
      if (ov0 && ordy0) begin
        chk("sb0_nonempty", 8'(q0.size() != 0), 8'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk("sb0_data", od0, e);
        end
      end
      if (flush) q0.delete();
      else if (iv0 && ir0) q0.push_back(id0 & ~(sup0 ? SUP : 8'h00));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    iv1 = 1'b0; id1 = 8'h00; sup1 = 1'b0; ordy1 = 1'b0;
    iv0 = 1'b0; id0 = 8'h00; sup0 = 1'b0; ordy0 = 1'b0;
    cyc(); cyc();
    chk("rst_ov1", ov1, 8'd0);
    chk("rst_occ1", occ1, 8'd0);
    chk("rst_od1", od1, 8'h00);
    chk("rst_ov0", ov0, 8'd0);
    chk("rst_od0", od0, 8'h00);
    rst = 1'b0;
    cyc();
    chk("rst_ir1", ir1, 8'd1);

    // basic flow
    iv1 = 1'b1; id1 = 8'h5A; ordy1 = 1'b1;
    cyc();
    iv1 = 1'b0;
    chk("basic_ov", ov1, 8'd1);
    chk("basic_od", od1, 8'h5A);
    chk("basic_occ", occ1, 8'd1);
    cyc();
    chk("basic_drain_ov", ov1, 8'd0);

    // back-pressure into skid
    ordy1 = 1'b0; iv1 = 1'b1; id1 = 8'h11;
    cyc();
    id1 = 8'h22;
    cyc();
    iv1 = 1'b0;
    chk("bp_occ2", occ1, 8'd2);
    chk("bp_ir0", ir1, 8'd0);
    chk("bp_head", od1, 8'h11);
    ordy1 = 1'b1;
    cyc();
    chk("bp_ir1", ir1, 8'd1);
    chk("bp_second", od1, 8'h22);
    chk("bp_occ1", occ1, 8'd1);
    cyc();
    chk("bp_occ0", occ1, 8'd0);
    ordy1 = 1'b0;

    // flush while full
    iv1 = 1'b1; id1 = 8'hAB;
    cyc();
    id1 = 8'hCD;
    cyc();
    id1 = 8'h77; flush = 1'b1;
    cyc();
    flush = 1'b0; iv1 = 1'b0;
    chk("fl_ov", ov1, 8'd0);
    chk("fl_occ", occ1, 8'd0);
    chk("fl_od", od1, 8'h0B);
    chk("fl_ir", ir1, 8'd1);

    // flush while one held and input ready
    iv1 = 1'b1; id1 = 8'h3C;
    cyc();
    id1 = 8'h77; flush = 1'b1;
    cyc();
    flush = 1'b0; iv1 = 1'b0;
    chk("fl1_ov", ov1, 8'd0);
    chk("fl1_od", od1, 8'h0C);
    chk("fl1_occ", occ1, 8'd0);
    ordy1 = 1'b1;
    cyc(); cyc();
    chk("fl1_still_empty", ov1, 8'd0);

    // suppress mask
    iv1 = 1'b1; id1 = 8'hFF; sup1 = 1'b1;
    cyc();
    chk("sup_on", od1, 8'h7E);
    sup1 = 1'b0;
    cyc();
    chk("sup_off", od1, 8'hFF);
    chk("sup_occ", occ1, 8'd1);
    iv1 = 1'b0;
    cyc();
    chk("sup_drain", ov1, 8'd0);

    // reset beats flush and accept while full
    ordy1 = 1'b0; iv1 = 1'b1; id1 = 8'h44;
    cyc();
    id1 = 8'h55;
    cyc();
    chk("rp_full", occ1, 8'd2);
    id1 = 8'h99; rst = 1'b1; flush = 1'b1; ordy1 = 1'b1;
    cyc();
    rst = 1'b0; flush = 1'b0; iv1 = 1'b0; ordy1 = 1'b0;
    chk("rp_ov", ov1, 8'd0);
    chk("rp_occ", occ1, 8'd0);
    chk("rp_od", od1, 8'h00);
    chk("rp_ir", ir1, 8'd1);

    // SKID=0 stream with a one-cycle stall
    iv0 = 1'b1; ordy0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) begin
        ordy0 = 1'b0;
        #1;
        chk("s0_stall_ir", ir0, 8'd0);
        cyc();
        chk("s0_stall_hold", od0, 8'h04);
        chk("s0_stall_ov", ov0, 8'd1);
        ordy0 = 1'b1;
      end
      id0 = 8'(k);
      cyc();
      chk("s0_data", od0, 8'(k));
      chk("s0_occ", occ0, 8'd1);
    end
    iv0 = 1'b0;
    cyc();
    chk("s0_drain", ov0, 8'd0);
    chk("sb1_leftover", 8'(q1.size()), 8'd0);
    chk("sb0_leftover", 8'(q0.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the in-order core. It replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MM1, ...).
- Carries an opaque packed payload with a valid/ready handshake and an optional 2-entry skid buffer, so that back-pressure does not form a combinational ready chain.
- Supports a stage-wide flush that kills in-flight entries.
- Supports per-field clearing, selected by bit masks:
  - clear-on-flush bits;
  - suppress bits, used for the "flush-before" case that cancels memory and register-write side effects.

Parameters:
- DATA_W, 64: payload width in bits. Legal range 1..1024.
- CLR_MASK, {DATA_W{1'b1}}: payload bits forced to 0 in both entries on flush. Bits not set hold their old value.
- SUP_MASK, {DATA_W{1'b0}}: payload bits forced to 0 at capture when in_sup=1.
- SKID, 1: 1 selects a 2-entry skid buffer with registered in_ready. 0 selects a single entry with in_ready = !out_valid | out_ready.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Synchronous, active-high reset.
- flush  in  1  Kill all held entries; also kills a same-cycle input.
- in_valid  in  1  Upstream entry valid.
- in_ready  out  1  Stage can accept an entry.
- in_data  in  DATA_W  Upstream payload.
- in_sup  in  1  Apply SUP_MASK to the entry being captured.
- out_valid  out  1  Head entry valid.
- out_ready  in  1  Downstream accepts the head.
- out_data  out  DATA_W  Head payload.
- occupancy  out  2  Number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values (next edge after rst=1):
  - out_valid=0, occupancy=0, out_data=0, skid payload=0.
  - in_ready=1 from the cycle after reset.
  - rst has priority over flush and over all handshakes.
- Transfers:
  - Accept occurs when in_valid & in_ready & !flush.
  - Pop occurs when out_valid & out_ready.
- Captured value: cap = in_data & ~(SUP_MASK & {DATA_W{in_sup}}).
- SKID=1 state, encoded as {main_v, skid_v}:
  - EMPTY (0,0):
    - accept -> ONE, with main=cap.
  - ONE (1,0):
    - accept and pop -> ONE, with main=cap.
    - accept only -> FULL, with skid=cap.
    - pop only -> EMPTY.
  - FULL (1,1):
    - in_ready=0.
    - pop -> ONE, with main=skid.
    - No accept is possible.
- SKID=1 ready rule: in_ready = !skid_v and is driven straight from a flop, with no combinational path from out_ready.
- SKID=0:
  - Single entry, main only.
  - in_ready = !main_v | out_ready.
  - Accept and pop in the same cycle replaces the entry.
- Latency and throughput:
  - Accept at edge N gives out_valid=1 at N+1.
  - Sustained throughput is 1 entry per cycle when out_ready=1.
  - Order is strictly FIFO.
- Flush (rst=0, flush=1) at edge N:
  - main_v=0 and skid_v=0 at N+1.
  - Bits of main and skid in CLR_MASK become 0; other bits hold.
  - The input offered in the same cycle is dropped, even if in_valid=1.
  - out_ready is ignored that cycle; a pop still counts downstream if out_valid & out_ready, since the handshake is sampled by the consumer.
  - in_ready=1 at N+1.
- Outputs when invalid: out_data shows the main payload (masked after a flush). Consumers must qualify with out_valid.
- occupancy = main_v + skid_v. It is registered and never exceeds 2.
- Invariants:
  - skid_v implies main_v.
  - No accept when in_ready=0.
  - A dropped input (in_valid & !in_ready) must be held by upstream; the block does not latch it.

Decomposition:
- Shared package or defs include:
  - the stage payload bit-layout offsets (exception flags, csr fields, mm fields, reg_d, op, pc);
  - the per-stage CLR_MASK and SUP_MASK constants built from those offsets, e.g. SUP_MASK covers mm_re, mm_we and reg_d_wen.
- Sub-module: pipe_entry_reg, one payload flop with load/clear-mask enable. It is instantiated twice (main, skid).

Test Plan:
- Reset and basic flow, with DATA_W=8, SKID=1:
  - Stimulus: rst=1 for 2 cycles, then in_valid=1, in_data=0x5A, out_ready=1.
  - Required: out_valid=1 and out_data=0x5A one cycle after the accept; occupancy=1.
- Back-pressure and skid:
  - Stimulus: out_ready=0; send 0x11 then 0x22.
  - Required: occupancy=2 and in_ready=0 on the next cycle.
  - Then out_ready=1: outputs 0x11, then 0x22 on consecutive cycles; in_ready=1 after the first pop.
- Flush with CLR_MASK=8'hF0:
  - Stimulus: hold 0xAB (main) and 0xCD (skid); flush=1 with in_valid=1, in_data=0x77.
  - Required: next cycle out_valid=0, occupancy=0, out_data=0x0B; 0x77 never appears.
- Suppress with SUP_MASK=8'h81:
  - Stimulus: in_data=0xFF with in_sup=1.
  - Required: out_data=0x7E.
  - Same input with in_sup=0 gives out_data=0xFF.
- SKID=0, continuous stream:
  - Stimulus: 0x01..0x08 on consecutive cycles with out_ready=1.
  - Required: outputs 0x01..0x08 back-to-back, 1-cycle latency.
  - Deassert out_ready for 1 cycle: in_ready=0 in that same cycle; no loss, no duplication.
- Reset priority:
  - Stimulus: rst=1 together with flush=1 and an accept while FULL.
  - Required: all state zero next cycle; out_data=0x00.
